// File: rtl/fdc_pkg.sv
// Shared definitions for the FDC-side head positioner: FSM encoding, default
// timing and Shugart cable polarities.
package fdc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDirSetup,
    StPulse,
    StGap,
    StSettle,
    StDone
  } fdc_state_e;

  localparam int unsigned DefTrkW      = 7;
  localparam int unsigned DefMaxTrack  = 79;
  localparam int unsigned DefRecalMax  = 85;
  localparam int unsigned DefDirCyc    = 100;
  localparam int unsigned DefPulseCyc  = 150;
  localparam int unsigned DefStepCyc   = 150000;
  localparam int unsigned DefSettleCyc = 750000;

  localparam logic StepActive   = 1'b0;
  localparam logic StepIdle     = 1'b1;
  localparam logic DirIn        = 1'b0;
  localparam logic DirOut       = 1'b1;
  localparam logic Track0Active = 1'b0;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level from the drive cable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fdc_seek_ctrl.sv
// Shugart-interface head positioner: turns seek/recalibrate commands into timed
// step pulses on step_n/dir_n and tracks the current cylinder.
module fdc_seek_ctrl
  import fdc_pkg::*;
#(
  parameter int unsigned TRK_W      = DefTrkW,
  parameter int unsigned MAX_TRACK  = DefMaxTrack,
  parameter int unsigned RECAL_MAX  = DefRecalMax,
  parameter int unsigned DIR_CYC    = DefDirCyc,
  parameter int unsigned PULSE_CYC  = DefPulseCyc,
  parameter int unsigned STEP_CYC   = DefStepCyc,
  parameter int unsigned SETTLE_CYC = DefSettleCyc
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_recal,
  input  logic [TRK_W-1:0] cmd_track,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [TRK_W-1:0] cur_track,
  output logic             track_valid,
  output logic             step_n,
  output logic             dir_n,
  input  logic             track0_n
);

  localparam int unsigned TMR_W = $clog2(max2(max2(STEP_CYC, SETTLE_CYC), DIR_CYC) + 1);
  localparam int unsigned CNT_W = $clog2(RECAL_MAX + 1);

  localparam logic [TMR_W-1:0] DirLoad    = TMR_W'(DIR_CYC - 1);
  localparam logic [TMR_W-1:0] PulseLoad  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GapLoad    = TMR_W'(STEP_CYC - PULSE_CYC - 1);
  // Loaded with the full count so done lands one cycle after settle expires.
  localparam logic [TMR_W-1:0] SettleLoad = TMR_W'(SETTLE_CYC);
  localparam logic [TRK_W-1:0] MaxTrk     = TRK_W'(MAX_TRACK);
  localparam logic [CNT_W-1:0] RecalMaxC  = CNT_W'(RECAL_MAX);

  fdc_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TRK_W-1:0] cur_track_q, cur_track_d;
  logic [TRK_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] npulse_q, npulse_d;
  logic             track_valid_q, track_valid_d;
  logic             recal_q, recal_d;
  logic             err_q, err_d;
  logic             dir_n_q, dir_n_d;
  logic             step_n_q;
  logic             t0_sync_n;
  logic             t0;
  logic             accept;
  logic             pulse_entry;
  logic [TRK_W-1:0] next_trk;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_t0_sync (
    .clk(clk),
    .rst(rst),
    .d  (track0_n),
    .q  (t0_sync_n)
  );

  assign t0     = (t0_sync_n == Track0Active);
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      cur_track_q   <= '0;
      tgt_q         <= '0;
      npulse_q      <= '0;
      track_valid_q <= 1'b0;
      recal_q       <= 1'b0;
      err_q         <= 1'b0;
      dir_n_q       <= DirOut;
      step_n_q      <= StepIdle;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cur_track_q   <= cur_track_d;
      tgt_q         <= tgt_d;
      npulse_q      <= npulse_d;
      track_valid_q <= track_valid_d;
      recal_q       <= recal_d;
      err_q         <= err_d;
      dir_n_q       <= dir_n_d;
      step_n_q      <= (state_d == StPulse) ? StepActive : StepIdle;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    cur_track_d   = cur_track_q;
    tgt_d         = tgt_q;
    npulse_d      = npulse_q;
    track_valid_d = track_valid_q;
    recal_d       = recal_q;
    err_d         = err_q;
    dir_n_d       = dir_n_q;
    pulse_entry   = 1'b0;
    // Saturating step so the cylinder count can never wrap.
    if (dir_n_q == DirIn) begin
      next_trk = (cur_track_q == '1) ? cur_track_q : cur_track_q + 1'b1;
    end else begin
      next_trk = (cur_track_q == '0) ? cur_track_q : cur_track_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          recal_d  = cmd_recal;
          tgt_d    = cmd_track;
          err_d    = 1'b0;
          npulse_d = '0;
          timer_d  = DirLoad;
          if (cmd_recal) begin
            dir_n_d       = DirOut;
            track_valid_d = 1'b0;
            state_d       = StDirSetup;
          end else begin
            dir_n_d = (cmd_track > cur_track_q) ? DirIn : DirOut;
            if (!track_valid_q || (cmd_track > MaxTrk)) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else if (cmd_track == cur_track_q) begin
              state_d = StDone;
            end else begin
              state_d = StDirSetup;
            end
          end
        end
      end
      StDirSetup, StGap: begin
        if (timer_q == '0) pulse_entry = 1'b1;
      end
      StPulse: begin
        if (timer_q == '0) begin
          if (npulse_q != RecalMaxC) npulse_d = npulse_q + 1'b1;
          state_d = StGap;
          timer_d = GapLoad;
          if (!recal_q) begin
            cur_track_d = next_trk;
            if (next_trk == tgt_q) begin
              state_d = StSettle;
              timer_d = SettleLoad;
            end
          end
        end
      end
      StSettle: begin
        if (timer_q == '0) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Track-0 is only trusted at the boundary before a pulse would start.
    if (pulse_entry) begin
      state_d = StPulse;
      timer_d = PulseLoad;
      if (recal_q) begin
        if (t0) begin
          cur_track_d   = '0;
          track_valid_d = 1'b1;
          state_d       = (npulse_q == '0) ? StDone : StSettle;
          timer_d       = SettleLoad;
        end else if (npulse_q == RecalMaxC) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end else if ((dir_n_q == DirOut) && t0) begin
        cur_track_d   = '0;
        track_valid_d = 1'b1;
        err_d         = 1'b1;
        state_d       = StDone;
      end
    end
  end

  always_comb begin
    cmd_ready   = (state_q == StIdle) && !rst;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    err         = (state_q == StDone) && err_q;
    cur_track   = cur_track_q;
    track_valid = track_valid_q;
    step_n      = step_n_q;
    dir_n       = dir_n_q;
  end

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Scoreboard bench for fdc_seek_ctrl with a simple drive head model behind the
// cable signals; expected completions are queued at issue and checked on done.
module tb_fdc_seek_ctrl;

  localparam int TrkW = 7;

  typedef struct {
    string name;
    int    lat;
    int    pulses;
    bit    err;
    int    cur;
    bit    valid;
    bit    dir;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_recal = 1'b0;
  logic [TrkW-1:0] cmd_track = '0;
  logic            busy;
  logic            done;
  logic            err;
  logic [TrkW-1:0] cur_track;
  logic            track_valid;
  logic            step_n;
  logic            dir_n;
  logic            track0_n;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  int head  = 0;
  bit stuck = 1'b0;
  bit model_en = 1'b0;

  always #5 clk = ~clk;

  fdc_seek_ctrl #(
    .TRK_W     (TrkW),
    .MAX_TRACK (79),
    .RECAL_MAX (85),
    .DIR_CYC   (2),
    .PULSE_CYC (4),
    .STEP_CYC  (20),
    .SETTLE_CYC(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_recal  (cmd_recal),
    .cmd_track  (cmd_track),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cur_track  (cur_track),
    .track_valid(track_valid),
    .step_n     (step_n),
    .dir_n      (dir_n),
    .track0_n   (track0_n)
  );

  // Drive head moves on the trailing (rising) edge of each step pulse.
  always @(posedge step_n) begin
    if (model_en) begin
      if (dir_n == 1'b0) begin
        if (head < 79) head++;
      end else if (head > 0) begin
        head--;
      end
    end
  end

  assign track0_n = stuck ? 1'b1 : (head != 0);

  function automatic void check(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    end
  endfunction

  function automatic exp_t mk(string nm, int lat, int pulses, bit e, int cur, bit v, bit d);
    exp_t x;
    x.name = nm; x.lat = lat; x.pulses = pulses; x.err = e;
    x.cur = cur; x.valid = v; x.dir = d;
    return x;
  endfunction

  // Monitor: latency counts edges after the accept edge, pulses count step_n falls.
  int armed = 0;
  int lat = 0;
  int pulses = 0;
  logic prev_step = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      armed = 0;
      exp_q.delete();
    end else begin
      if (armed != 0) begin
        lat++;
        if (step_n == 1'b0 && prev_step == 1'b1) pulses++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".lat"}, lat, e.lat);
          check({e.name, ".pulses"}, pulses, e.pulses);
          check({e.name, ".err"}, int'(err), int'(e.err));
          check({e.name, ".cur_track"}, int'(cur_track), e.cur);
          check({e.name, ".track_valid"}, int'(track_valid), int'(e.valid));
          check({e.name, ".dir_n"}, int'(dir_n), int'(e.dir));
        end
        armed = 0;
      end
      if (cmd_valid && cmd_ready) begin
        armed  = 1;
        lat    = -1;
        pulses = 0;
      end
    end
    prev_step = step_n;
  end

  task automatic issue(bit recal, int trk, exp_t e);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({e.name, ".ready_timeout"}, int'(cmd_ready), 1);
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_recal = recal;
    cmd_track = TrkW'(trk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, ".done_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst.cmd_ready", int'(cmd_ready), 0);
    check("rst.step_n", int'(step_n), 1);
    check("rst.dir_n", int'(dir_n), 1);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.err", int'(err), 0);
    check("rst.cur_track", int'(cur_track), 0);
    check("rst.track_valid", int'(track_valid), 0);
    rst = 1'b0;
    model_en = 1'b1;
    @(posedge clk); #1;
    check("post_rst.cmd_ready", int'(cmd_ready), 1);

    issue(1'b0, 5, mk("seek_noval", 0, 0, 1'b1, 0, 1'b0, 1'b0));
    wait_done("seek_noval");

    head = 5;
    issue(1'b1, 0, mk("recal5", 113, 5, 1'b0, 0, 1'b1, 1'b1));
    wait_done("recal5");

    issue(1'b0, 3, mk("seek3", 57, 3, 1'b0, 3, 1'b1, 1'b0));
    wait_done("seek3");
    check("seek3.head", head, 3);

    issue(1'b0, 3, mk("seek_same", 0, 0, 1'b0, 3, 1'b1, 1'b1));
    wait_done("seek_same");

    issue(1'b0, 80, mk("seek80", 0, 0, 1'b1, 3, 1'b1, 1'b0));
    wait_done("seek80");

    issue(1'b0, 1, mk("seek_out1", 37, 2, 1'b0, 1, 1'b1, 1'b1));
    wait_done("seek_out1");
    check("seek_out1.head", head, 1);

    stuck = 1'b1;
    issue(1'b1, 0, mk("recal_stuck", 1702, 85, 1'b1, 1, 1'b0, 1'b1));
    wait_done("recal_stuck");
    stuck = 1'b0;

    issue(1'b0, 2, mk("seek_after_fail", 0, 0, 1'b1, 1, 1'b0, 1'b0));
    wait_done("seek_after_fail");

    head = 5;
    issue(1'b1, 0, mk("recal_rst", 0, 0, 1'b0, 0, 1'b0, 1'b1));
    n = 0;
    while (step_n && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("midpulse.step_low", int'(step_n), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midpulse.step_n", int'(step_n), 1);
    check("midpulse.busy", int'(busy), 0);
    check("midpulse.track_valid", int'(track_valid), 0);
    check("midpulse.cur_track", int'(cur_track), 0);
    check("midpulse.cmd_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    if (head > 0) begin
      issue(1'b1, 0, mk("recal_again", 2 + head * 20 + 11, head, 1'b0, 0, 1'b1, 1'b1));
    end else begin
      issue(1'b1, 0, mk("recal_again", 2, 0, 1'b0, 0, 1'b1, 1'b1));
    end
    wait_done("recal_again");
    check("recal_again.head", head, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

endmodule
